// File: rtl/posit_pkg.sv
// Shared sizing helpers and the unpacked posit record for the posit front end.
// The record is fixed at the default 8/1 geometry; it is the canonical unpacked view.
package posit_pkg;

    function automatic int getSignedExponentBits(input int width, input int es);
        return $clog2(((width - 2) << es) + 1) + 1;
    endfunction

    function automatic int getFractionBits(input int width, input int es);
        return width - 3 - es;
    endfunction

    localparam int UNPACKED_WIDTH = 8;
    localparam int UNPACKED_ES    = 1;
    localparam int UNPACKED_M     = getSignedExponentBits(UNPACKED_WIDTH, UNPACKED_ES);
    localparam int UNPACKED_F     = getFractionBits(UNPACKED_WIDTH, UNPACKED_ES);

    typedef struct packed {
        logic                  sign;
        logic                  isInf;
        logic                  isZero;
        logic [UNPACKED_M-1:0] exp;
        logic [UNPACKED_F-1:0] frac;
    } posit_unpacked_t;

endpackage

// File: rtl/posit_decode_if.sv
// Compact posit in, unpacked fields out. Handshake: in_valid qualifies in_bits for one
// cycle with no backpressure; out_valid is in_valid delayed one cycle and qualifies out_*.
interface posit_decode_if #(
    parameter int WIDTH = 8,
    parameter int ES    = 1
);
    import posit_pkg::*;

    localparam int M = getSignedExponentBits(WIDTH, ES);
    localparam int F = getFractionBits(WIDTH, ES);

    logic             in_valid;
    logic [WIDTH-1:0] in_bits;
    logic             out_valid;
    logic             out_sign;
    logic             out_isZero;
    logic             out_isInf;
    logic [M-1:0]     out_exp;
    logic [F-1:0]     out_frac;

    modport master (
        output in_valid, in_bits,
        input  out_valid, out_sign, out_isZero, out_isInf, out_exp, out_frac
    );

    modport slave (
        input  in_valid, in_bits,
        output out_valid, out_sign, out_isZero, out_isInf, out_exp, out_frac
    );

endinterface

// File: rtl/posit_regime_count.sv
// Leading-run counter: length of the run of bits equal to the MSB, and that MSB.
module posit_regime_count #(
    parameter int N  = 7,
    parameter int RW = $clog2(N + 1)
) (
    input  logic [N-1:0]  body,
    output logic [RW-1:0] run,
    output logic          polarity
);

    logic stop;

    always_comb begin
        polarity = body[N-1];
        run      = '0;
        stop     = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!stop) begin
                if (body[i] == polarity) begin
                    run = run + RW'(1);
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/posit_decode.sv
// Posit decoder: combinational unpack of sign/regime/exponent/fraction, one register stage.
module posit_decode
    import posit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ES    = 1
) (
    input  logic          clock,
    input  logic          reset,
    posit_decode_if.slave bus
);

    localparam int N  = WIDTH - 1;
    localparam int M  = getSignedExponentBits(WIDTH, ES);
    localparam int F  = getFractionBits(WIDTH, ES);
    localparam int RW = $clog2(N + 1);

    logic          sign;
    logic [N-1:0]  low;
    logic [N-1:0]  body;
    logic [RW-1:0] run;
    logic          polarity;
    logic [RW:0]   shamt;
    logic [N-3:0]  field;
    logic [M-1:0]  run_m;
    logic [M-1:0]  k;
    logic [M-1:0]  e_m;
    logic [M-1:0]  scale;
    logic          is_zero;
    logic          is_inf;

    assign sign    = bus.in_bits[WIDTH-1];
    assign low     = bus.in_bits[N-1:0];
    assign body    = sign ? (~low + N'(1)) : low;
    assign is_zero = (bus.in_bits == '0);
    assign is_inf  = sign && (low == '0);

    posit_regime_count #(.N(N), .RW(RW)) u_regime (
        .body     (body),
        .run      (run),
        .polarity (polarity)
    );

    // Drop regime and terminator; what is left is e then fraction, MSB-aligned, zero-filled.
    assign shamt = {1'b0, run} + (RW + 1)'(1);
    assign field = (N - 2)'((body << shamt) >> 2);

    assign run_m = M'(run);
    assign k     = polarity ? (run_m - M'(1)) : (M'(0) - run_m);
    assign e_m   = M'(field >> F);
    assign scale = (k << ES) + e_m;

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.out_valid  <= 1'b0;
            bus.out_sign   <= 1'b0;
            bus.out_isZero <= 1'b0;
            bus.out_isInf  <= 1'b0;
            bus.out_exp    <= '0;
            bus.out_frac   <= '0;
        end else begin
            bus.out_valid  <= bus.in_valid;
            bus.out_isZero <= is_zero;
            bus.out_isInf  <= is_inf;
            // Specials carry no numeric fields.
            if (is_zero || is_inf) begin
                bus.out_sign <= 1'b0;
                bus.out_exp  <= '0;
                bus.out_frac <= '0;
            end else begin
                bus.out_sign <= sign;
                bus.out_exp  <= scale;
                bus.out_frac <= field[F-1:0];
            end
        end
    end

endmodule

// File: tb/tb_posit_decode.sv
// Bench for posit_decode at 8/1: directed codes, back-to-back stream, resets, full sweep.
module tb_posit_decode;
    import posit_pkg::*;

    localparam int WIDTH = 8;
    localparam int ES    = 1;
    localparam int M     = UNPACKED_M;
    localparam int F     = UNPACKED_F;
    localparam int UW    = $bits(posit_unpacked_t);

    logic clock = 1'b0;
    logic reset;

    posit_decode_if #(.WIDTH(WIDTH), .ES(ES)) bus ();

    posit_decode #(.WIDTH(WIDTH), .ES(ES)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [UW-1:0] exp_q[$];
    int checks = 0;
    int passed = 0;
    int fails  = 0;

    function automatic posit_unpacked_t mk(input logic s, input logic inf, input logic z,
                                           input int e, input int f);
        posit_unpacked_t u;
        u.sign   = s;
        u.isInf  = inf;
        u.isZero = z;
        u.exp    = M'(e);
        u.frac   = F'(f);
        return u;
    endfunction

    // Bit-walking reference: pointer i steps through the magnitude, reading 0 past the LSB.
    function automatic posit_unpacked_t model(input logic [7:0] b);
        logic [7:0] a;
        logic       r;
        int         i;
        int         run;
        int         k;
        int         e;
        int         f;
        if (b == 8'h00) return mk(1'b0, 1'b0, 1'b1, 0, 0);
        if (b == 8'h80) return mk(1'b0, 1'b1, 1'b0, 0, 0);
        a   = b[7] ? (8'h00 - b) : b;
        r   = a[6];
        i   = 6;
        run = 0;
        while (i >= 0 && a[i[2:0]] == r) begin
            run++;
            i--;
        end
        k = r ? run - 1 : -run;
        i--;
        e = 0;
        for (int j = 0; j < ES; j++) begin
            e = e * 2 + ((i >= 0) ? int'(a[i[2:0]]) : 0);
            i--;
        end
        f = 0;
        for (int j = 0; j < F; j++) begin
            f = f * 2 + ((i >= 0) ? int'(a[i[2:0]]) : 0);
            i--;
        end
        return mk(b[7], 1'b0, 1'b0, k * (1 << ES) + e, f);
    endfunction

    task automatic check(input string tag, input logic valid_exp, input posit_unpacked_t fexp);
        posit_unpacked_t obs;
        obs = {bus.out_sign, bus.out_isInf, bus.out_isZero, bus.out_exp, bus.out_frac};
        checks++;
        assert (bus.out_valid === valid_exp) passed++;
        else begin
            fails++;
            $error("FAIL %s out_valid got %b want %b", tag, bus.out_valid, valid_exp);
        end
        checks++;
        assert (obs === fexp) passed++;
        else begin
            fails++;
            $error("FAIL %s fields got s=%b inf=%b zero=%b exp=%h frac=%h want s=%b inf=%b zero=%b exp=%h frac=%h",
                   tag, obs.sign, obs.isInf, obs.isZero, obs.exp, obs.frac,
                   fexp.sign, fexp.isInf, fexp.isZero, fexp.exp, fexp.frac);
        end
    endtask

    task automatic pop_check(input string tag);
        posit_unpacked_t fexp;
        if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL %s scoreboard empty got out_valid=%b want a queued entry", tag, bus.out_valid);
        end else begin
            fexp = exp_q.pop_front();
            check(tag, 1'b1, fexp);
        end
    endtask

    // Drive one code a little after an edge, push its expectation, check after the next edge.
    task automatic send(input string tag, input logic [7:0] b, input posit_unpacked_t fexp);
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bits  = b;
        exp_q.push_back(fexp);
        @(posedge clock);
        #1;
        pop_check(tag);
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_bits  = 8'h48;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset", 1'b0, mk(1'b0, 1'b0, 1'b0, 0, 0));

        send("one_0x40",      8'h40, mk(1'b0, 1'b0, 1'b0, 0, 4'b0000));
        send("one_half_0x48", 8'h48, mk(1'b0, 1'b0, 1'b0, 0, 4'b1000));
        send("two_0x50",      8'h50, mk(1'b0, 1'b0, 1'b0, 1, 0));
        send("four_0x60",     8'h60, mk(1'b0, 1'b0, 1'b0, 2, 0));
        send("maxpos_0x7f",   8'h7F, mk(1'b0, 1'b0, 1'b0, 12, 0));
        send("minpos_0x01",   8'h01, mk(1'b0, 1'b0, 1'b0, -12, 0));
        send("neg_one_0xc0",  8'hC0, mk(1'b1, 1'b0, 1'b0, 0, 0));
        send("neg_1p5_0xb8",  8'hB8, mk(1'b1, 1'b0, 1'b0, 0, 4'b1000));
        send("zero_0x00",     8'h00, mk(1'b0, 1'b0, 1'b1, 0, 0));
        send("nar_0x80",      8'h80, mk(1'b0, 1'b1, 1'b0, 0, 0));

        send("b2b_0x40", 8'h40, mk(1'b0, 1'b0, 1'b0, 0, 0));
        send("b2b_0x7f", 8'h7F, mk(1'b0, 1'b0, 1'b0, 12, 0));
        send("b2b_0x80", 8'h80, mk(1'b0, 1'b1, 1'b0, 0, 0));

        // Fields follow in_bits even when the input is not valid.
        bus.in_valid = 1'b0;
        bus.in_bits  = 8'h50;
        @(posedge clock);
        #1;
        check("idle_load", 1'b0, mk(1'b0, 1'b0, 1'b0, 1, 0));

        send("pre_reset_0x60", 8'h60, mk(1'b0, 1'b0, 1'b0, 2, 0));
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bits  = 8'h7F;
        @(posedge clock);
        #1;
        check("mid_reset", 1'b0, mk(1'b0, 1'b0, 1'b0, 0, 0));
        reset = 1'b0;

        for (int c = 0; c < 256; c++) begin
            send($sformatf("sweep_%02h", c), 8'(c), model(8'(c)));
        end

        checks++;
        assert (exp_q.size() == 0) passed++;
        else begin
            fails++;
            $error("FAIL drain queue size got %0d want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
